wb_regfile: RTL and testbench

//   Architectural state sink at the far end of the writeback interface: 32x32 GPR file
//   (x0 hardwired zero), machine CSRs (mstatus/mtvec/mepc/mcause) and mcycle/minstret

---
 rtl/core_pkg.sv | 24 ++
 rtl/wb_csr_file.sv | 67 ++++++
 rtl/wb_regfile.sv | 90 +++++++++
 tb/tb_wb_regfile.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared definitions for the writeback-side architectural state: CSR read selectors,
// CSR write-enable bit positions and reset defaults.
package core_pkg;

  localparam int CORE_XLEN = 32;
  localparam logic [CORE_XLEN-1:0] MSTATUS_RST_DEFAULT = 32'h0000_1800;

  typedef enum logic [2:0] {
    CSR_MSTATUS     = 3'd0,
    CSR_MTVEC       = 3'd1,
    CSR_MEPC        = 3'd2,
    CSR_MCAUSE      = 3'd3,
    CSR_MCYCLE_LO   = 3'd4,
    CSR_MCYCLE_HI   = 3'd5,
    CSR_MINSTRET_LO = 3'd6,
    CSR_MINSTRET_HI = 3'd7
  } csr_sel_e;

  localparam int CSR_WEN_MSTATUS = 0;
  localparam int CSR_WEN_MTVEC   = 1;
  localparam int CSR_WEN_MEPC    = 2;
  localparam int CSR_WEN_MCAUSE  = 3;

endpackage

// File: rtl/wb_csr_file.sv
// Machine CSRs (mstatus/mtvec/mepc/mcause) plus mcycle/minstret counters, with a
// combinational read mux that forwards same-cycle CSR writes.
module wb_csr_file
  import core_pkg::*;
#(
  parameter int              XLEN        = CORE_XLEN,
  parameter int              CNT_W       = 64,
  parameter logic [XLEN-1:0] MSTATUS_RST = MSTATUS_RST_DEFAULT
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            wb_valid,
  input  logic [3:0]      csr_wen,
  input  logic [XLEN-1:0] csrd,
  input  logic [2:0]      csr_rsel,
  output logic [XLEN-1:0] csr_rdata
);

  logic [XLEN-1:0]   mstatus, mtvec, mepc, mcause;
  logic [CNT_W-1:0]  mcycle, minstret;
  logic [2*XLEN-1:0] mcycle_ext, minstret_ext;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      mstatus  <= MSTATUS_RST;
      mtvec    <= '0;
      mepc     <= '0;
      mcause   <= '0;
      mcycle   <= '0;
      minstret <= '0;
    end else begin
      if (wb_valid && csr_wen[CSR_WEN_MSTATUS]) mstatus <= csrd;
      if (wb_valid && csr_wen[CSR_WEN_MTVEC])   mtvec   <= csrd;
      if (wb_valid && csr_wen[CSR_WEN_MEPC])    mepc    <= csrd;
      if (wb_valid && csr_wen[CSR_WEN_MCAUSE])  mcause  <= csrd;
      mcycle <= mcycle + CNT_W'(1);
      if (wb_valid) minstret <= minstret + CNT_W'(1);
    end
  end

  // Counters are zero-extended to two XLEN words so narrow builds still have a hi half.
  always_comb begin
    mcycle_ext   = '0;
    minstret_ext = '0;
    mcycle_ext[CNT_W-1:0]   = mcycle;
    minstret_ext[CNT_W-1:0] = minstret;
  end

  // NOTE: every output of this always_comb gets a default first so no latch is inferred.
  always_comb begin
    csr_rdata = '0;
    case (csr_sel_e'(csr_rsel))
      CSR_MSTATUS:     csr_rdata = mstatus;
      CSR_MTVEC:       csr_rdata = mtvec;
      CSR_MEPC:        csr_rdata = mepc;
      CSR_MCAUSE:      csr_rdata = mcause;
      CSR_MCYCLE_LO:   csr_rdata = mcycle_ext[XLEN-1:0];
      CSR_MCYCLE_HI:   csr_rdata = mcycle_ext[2*XLEN-1:XLEN];
      CSR_MINSTRET_LO: csr_rdata = minstret_ext[XLEN-1:0];
      CSR_MINSTRET_HI: csr_rdata = minstret_ext[2*XLEN-1:XLEN];
      default:         csr_rdata = '0;
    endcase
    if (!csr_rsel[2] && wb_valid && csr_wen[csr_rsel[1:0]]) csr_rdata = csrd;
  end

endmodule

// File: rtl/wb_regfile.sv
// Writeback-side architectural state: 32x32 GPR file with x0 hardwired to zero and
// bypassed read ports, plus the CSR file. Define WB_TRACE_EN to add retirement trace outputs.
module wb_regfile
  import core_pkg::*;
#(
  parameter int              XLEN        = CORE_XLEN,
  parameter int              CNT_W       = 64,
  parameter logic [XLEN-1:0] MSTATUS_RST = MSTATUS_RST_DEFAULT
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            wb_valid,
  input  logic            wb_rwen,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_rd_value,
  input  logic [3:0]      wb_csr_wen,
  input  logic [XLEN-1:0] wb_csrd,
  input  logic [XLEN-1:0] wb_pc,
  output logic            wb_ready,
  input  logic [4:0]      rs1_addr,
  input  logic [4:0]      rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  input  logic [2:0]      csr_rsel,
  output logic [XLEN-1:0] csr_rdata
`ifdef WB_TRACE_EN
  ,
  output logic            trace_valid,
  output logic [XLEN-1:0] trace_pc,
  output logic [4:0]      trace_rd,
  output logic [XLEN-1:0] trace_wdata,
  output logic            trace_rwen
`endif
);

  logic [XLEN-1:0] gpr [32];

  assign wb_ready = 1'b1;

  // NOTE: the GPR array is cleared on reset because software may read any register before writing it.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) gpr[i] <= '0;
    end else if (wb_rwen && wb_rd != 5'd0) begin
      gpr[wb_rd] <= wb_rd_value;
    end
  end

  assign rs1_data = (rs1_addr == 5'd0)                 ? '0          :
                    (wb_rwen && wb_rd == rs1_addr)     ? wb_rd_value : gpr[rs1_addr];
  assign rs2_data = (rs2_addr == 5'd0)                 ? '0          :
                    (wb_rwen && wb_rd == rs2_addr)     ? wb_rd_value : gpr[rs2_addr];

  wb_csr_file #(
    .XLEN        (XLEN),
    .CNT_W       (CNT_W),
    .MSTATUS_RST (MSTATUS_RST)
  ) u_csr (
    .clock     (clock),
    .reset     (reset),
    .wb_valid  (wb_valid),
    .csr_wen   (wb_csr_wen),
    .csrd      (wb_csrd),
    .csr_rsel  (csr_rsel),
    .csr_rdata (csr_rdata)
  );

`ifdef WB_TRACE_EN
  always_ff @(posedge clock) begin
    if (reset || !wb_valid) begin
      trace_valid <= 1'b0;
      trace_pc    <= '0;
      trace_rd    <= '0;
      trace_wdata <= '0;
      trace_rwen  <= 1'b0;
    end else begin
      trace_valid <= 1'b1;
      trace_pc    <= wb_pc;
      trace_rd    <= wb_rd;
      trace_wdata <= wb_rd_value;
      trace_rwen  <= wb_rwen;
    end
  end
`else
  // The retiring PC only feeds the trace path.
  logic unused_wb_pc;
  assign unused_wb_pc = ^wb_pc;
`endif

endmodule

// File: tb/tb_wb_regfile.sv
// Scoreboard bench for wb_regfile: expectations are queued as stimulus is driven and
// compared against DUT outputs sampled mid-cycle. Define WB_TRACE_EN to cover trace outputs.
module tb_wb_regfile;
  import core_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        wb_valid = 1'b0, wb_rwen = 1'b0;
  logic [4:0]  wb_rd = '0, rs1_addr = '0, rs2_addr = '0;
  logic [31:0] wb_rd_value = '0, wb_csrd = '0, wb_pc = '0;
  logic [3:0]  wb_csr_wen = '0;
  logic [2:0]  csr_rsel = '0;
  logic        wb_ready, s_wb_ready;
  logic [31:0] rs1_data, rs2_data, csr_rdata;
  logic [31:0] s_rs1_data, s_rs2_data, s_csr_rdata;
`ifdef WB_TRACE_EN
  logic        trace_valid, trace_rwen, s_trace_valid, s_trace_rwen;
  logic [31:0] trace_pc, trace_wdata, s_trace_pc, s_trace_wdata;
  logic [4:0]  trace_rd, s_trace_rd;
`endif

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] exp_q[$];
  logic [31:0] got_q[$];
  string       tag_q[$];
  logic [31:0] e, g;
  string       t;

  always #5 clock = ~clock;

  wb_regfile dut (
    .clock(clock), .reset(reset), .wb_valid(wb_valid), .wb_rwen(wb_rwen), .wb_rd(wb_rd),
    .wb_rd_value(wb_rd_value), .wb_csr_wen(wb_csr_wen), .wb_csrd(wb_csrd), .wb_pc(wb_pc),
    .wb_ready(wb_ready), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data),
    .rs2_data(rs2_data), .csr_rsel(csr_rsel), .csr_rdata(csr_rdata)
`ifdef WB_TRACE_EN
    , .trace_valid(trace_valid), .trace_pc(trace_pc), .trace_rd(trace_rd),
    .trace_wdata(trace_wdata), .trace_rwen(trace_rwen)
`endif
  );

  // Narrow-counter instance: same inputs, 8-bit counters so wraparound is reachable.
  wb_regfile #(.CNT_W(8)) dut_small (
    .clock(clock), .reset(reset), .wb_valid(wb_valid), .wb_rwen(wb_rwen), .wb_rd(wb_rd),
    .wb_rd_value(wb_rd_value), .wb_csr_wen(wb_csr_wen), .wb_csrd(wb_csrd), .wb_pc(wb_pc),
    .wb_ready(s_wb_ready), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(s_rs1_data),
    .rs2_data(s_rs2_data), .csr_rsel(csr_rsel), .csr_rdata(s_csr_rdata)
`ifdef WB_TRACE_EN
    , .trace_valid(s_trace_valid), .trace_pc(s_trace_pc), .trace_rd(s_trace_rd),
    .trace_wdata(s_trace_wdata), .trace_rwen(s_trace_rwen)
`endif
  );

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1; wb_valid = 1'b0; wb_rwen = 1'b0; wb_csr_wen = '0;
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    rs1_addr = 5'd5; rs2_addr = 5'd0; csr_rsel = CSR_MSTATUS;
    exp_q.push_back(32'h0);         tag_q.push_back("reset_rs1");
    exp_q.push_back(32'h0);         tag_q.push_back("reset_rs2");
    exp_q.push_back(32'h0000_1800); tag_q.push_back("reset_mstatus");
    exp_q.push_back(32'h1);         tag_q.push_back("wb_ready");
    #1;
    got_q.push_back(rs1_data); got_q.push_back(rs2_data);
    got_q.push_back(csr_rdata); got_q.push_back({31'b0, wb_ready});
    for (int s = 1; s < 8; s++) begin
      csr_rsel = 3'(s);
      exp_q.push_back(32'h0); tag_q.push_back($sformatf("reset_csr%0d", s));
      #1 got_q.push_back(csr_rdata);
    end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); t = tag_q.pop_front(); n_vec++;
      if (g !== e) begin n_err++; $display("FAIL %s: observed %h, required %h", t, g, e); end
    end
  endtask

  task automatic test_gpr();
    logic [31:0] v;
    @(negedge clock);
    wb_rwen = 1'b1; wb_rd = 5'd5; wb_rd_value = 32'hDEAD_BEEF; rs1_addr = 5'd5; rs2_addr = 5'd6;
    exp_q.push_back(32'hDEAD_BEEF); tag_q.push_back("bypass_rs1");
    exp_q.push_back(32'h0);         tag_q.push_back("bypass_other_rs2");
    #1 got_q.push_back(rs1_data); got_q.push_back(rs2_data);
    @(negedge clock);
    wb_rwen = 1'b0;
    exp_q.push_back(32'hDEAD_BEEF); tag_q.push_back("stored_rs1");
    #1 got_q.push_back(rs1_data);
    @(negedge clock);
    wb_rwen = 1'b1; wb_rd = 5'd0; wb_rd_value = 32'h1234; rs1_addr = 5'd0; rs2_addr = 5'd0;
    exp_q.push_back(32'h0); tag_q.push_back("x0_same_rs1");
    exp_q.push_back(32'h0); tag_q.push_back("x0_same_rs2");
    #1 got_q.push_back(rs1_data); got_q.push_back(rs2_data);
    @(negedge clock);
    wb_rwen = 1'b0;
    exp_q.push_back(32'h0); tag_q.push_back("x0_next_rs1");
    #1 got_q.push_back(rs1_data);
    // Fill x1..x31 with distinct patterns, checking the rs2 bypass on each write.
    for (int i = 1; i < 32; i++) begin
      @(negedge clock);
      v = 32'h9E37_79B9 * i;
      wb_rwen = 1'b1; wb_rd = 5'(i); wb_rd_value = v; rs2_addr = 5'(i);
      exp_q.push_back(v); tag_q.push_back($sformatf("fill_bypass_x%0d", i));
      #1 got_q.push_back(rs2_data);
    end
    @(negedge clock);
    wb_rwen = 1'b0;
    for (int i = 1; i < 32; i++) begin
      rs1_addr = 5'(i); rs2_addr = 5'((i % 31) + 1);
      exp_q.push_back(32'h9E37_79B9 * i);             tag_q.push_back($sformatf("read_rs1_x%0d", i));
      exp_q.push_back(32'h9E37_79B9 * ((i % 31) + 1)); tag_q.push_back($sformatf("read_rs2_x%0d", i));
      #1 got_q.push_back(rs1_data); got_q.push_back(rs2_data);
    end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); t = tag_q.pop_front(); n_vec++;
      if (g !== e) begin n_err++; $display("FAIL %s: observed %h, required %h", t, g, e); end
    end
  endtask

  task automatic test_csr();
    @(negedge clock);
    wb_valid = 1'b1; wb_csr_wen = 4'b0110; wb_csrd = 32'h8000_0100; csr_rsel = CSR_MTVEC;
    exp_q.push_back(32'h8000_0100); tag_q.push_back("csr_bypass_mtvec");
    #1 got_q.push_back(csr_rdata);
    csr_rsel = CSR_MSTATUS;
    exp_q.push_back(32'h0000_1800); tag_q.push_back("csr_unselected_mstatus");
    #1 got_q.push_back(csr_rdata);
    @(negedge clock);
    wb_valid = 1'b0; wb_csr_wen = '0;
    for (int s = 0; s < 4; s++) begin
      csr_rsel = 3'(s);
      exp_q.push_back((s == 1 || s == 2) ? 32'h8000_0100 : (s == 0) ? 32'h0000_1800 : 32'h0);
      tag_q.push_back($sformatf("csr_multi_%0d", s));
      #1 got_q.push_back(csr_rdata);
    end
    wb_csr_wen = 4'b1000; wb_csrd = 32'hDEAD_0001; csr_rsel = CSR_MCAUSE;
    exp_q.push_back(32'h0); tag_q.push_back("mcause_novalid_same");
    #1 got_q.push_back(csr_rdata);
    @(negedge clock);
    wb_csr_wen = '0;
    exp_q.push_back(32'h0); tag_q.push_back("mcause_novalid_next");
    #1 got_q.push_back(csr_rdata);
    @(negedge clock);
    wb_valid = 1'b1; wb_csr_wen = 4'b1111; wb_csrd = 32'hA5A5_5A5A;
    @(negedge clock);
    wb_valid = 1'b0; wb_csr_wen = '0;
    for (int s = 0; s < 4; s++) begin
      csr_rsel = 3'(s);
      exp_q.push_back(32'hA5A5_5A5A); tag_q.push_back($sformatf("csr_all_%0d", s));
      #1 got_q.push_back(csr_rdata);
    end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); t = tag_q.pop_front(); n_vec++;
      if (g !== e) begin n_err++; $display("FAIL %s: observed %h, required %h", t, g, e); end
    end
  endtask

  task automatic test_reset_override();
    @(negedge clock);
    reset = 1'b1; wb_valid = 1'b1; wb_rwen = 1'b1; wb_rd = 5'd7; wb_rd_value = 32'h7777_7777;
    wb_csr_wen = 4'b0011; wb_csrd = 32'h1111_2222;
    @(negedge clock);
    reset = 1'b0; wb_valid = 1'b0; wb_rwen = 1'b0; wb_csr_wen = '0;
    rs1_addr = 5'd7; rs2_addr = 5'd5;
    exp_q.push_back(32'h0); tag_q.push_back("rst_wins_x7");
    exp_q.push_back(32'h0); tag_q.push_back("rst_clears_x5");
    #1 got_q.push_back(rs1_data); got_q.push_back(rs2_data);
    csr_rsel = CSR_MSTATUS;
    exp_q.push_back(32'h0000_1800); tag_q.push_back("rst_wins_mstatus");
    #1 got_q.push_back(csr_rdata);
    csr_rsel = CSR_MTVEC;
    exp_q.push_back(32'h0); tag_q.push_back("rst_wins_mtvec");
    #1 got_q.push_back(csr_rdata);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); t = tag_q.pop_front(); n_vec++;
      if (g !== e) begin n_err++; $display("FAIL %s: observed %h, required %h", t, g, e); end
    end
  endtask

  task automatic test_counters();
    do_reset();
    wb_valid = 1'b1;
    repeat (10) @(negedge clock);
    wb_valid = 1'b0;
    repeat (5) @(negedge clock);
    for (int s = 4; s < 8; s++) begin
      csr_rsel = 3'(s);
      exp_q.push_back(s == 4 ? 32'd15 : s == 6 ? 32'd10 : 32'd0);
      tag_q.push_back($sformatf("counter_sel%0d", s));
      #1 got_q.push_back(csr_rdata);
    end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); t = tag_q.pop_front(); n_vec++;
      if (g !== e) begin n_err++; $display("FAIL %s: observed %h, required %h", t, g, e); end
    end
  endtask

  task automatic test_counter_wrap();
    do_reset();
    wb_valid = 1'b1;
    repeat (255) @(negedge clock);
    csr_rsel = CSR_MINSTRET_LO;
    exp_q.push_back(32'd255); tag_q.push_back("narrow_minstret_max");
    exp_q.push_back(32'd255); tag_q.push_back("wide_minstret_255");
    #1 got_q.push_back(s_csr_rdata); got_q.push_back(csr_rdata);
    @(negedge clock);
    wb_valid = 1'b0;
    exp_q.push_back(32'd0);   tag_q.push_back("narrow_minstret_wrap");
    exp_q.push_back(32'd256); tag_q.push_back("wide_minstret_carry");
    #1 got_q.push_back(s_csr_rdata); got_q.push_back(csr_rdata);
    csr_rsel = CSR_MINSTRET_HI;
    exp_q.push_back(32'd0); tag_q.push_back("narrow_minstret_hi");
    #1 got_q.push_back(s_csr_rdata);
    csr_rsel = CSR_MCYCLE_LO;
    exp_q.push_back(32'd0);   tag_q.push_back("narrow_mcycle_wrap");
    exp_q.push_back(32'd256); tag_q.push_back("wide_mcycle_256");
    #1 got_q.push_back(s_csr_rdata); got_q.push_back(csr_rdata);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); t = tag_q.pop_front(); n_vec++;
      if (g !== e) begin n_err++; $display("FAIL %s: observed %h, required %h", t, g, e); end
    end
  endtask

`ifdef WB_TRACE_EN
  task automatic test_trace();
    @(negedge clock);
    wb_valid = 1'b1; wb_pc = 32'h8000_0004; wb_rd = 5'd3; wb_rd_value = 32'd7; wb_rwen = 1'b1;
    exp_q.push_back(32'h1);         tag_q.push_back("trace_valid");
    exp_q.push_back(32'h8000_0004); tag_q.push_back("trace_pc");
    exp_q.push_back(32'd3);         tag_q.push_back("trace_rd");
    exp_q.push_back(32'd7);         tag_q.push_back("trace_wdata");
    exp_q.push_back(32'h1);         tag_q.push_back("trace_rwen");
    @(negedge clock);
    wb_valid = 1'b0; wb_rwen = 1'b0;
    #1 got_q.push_back({31'b0, trace_valid}); got_q.push_back(trace_pc);
    got_q.push_back({27'b0, trace_rd}); got_q.push_back(trace_wdata);
    got_q.push_back({31'b0, trace_rwen});
    exp_q.push_back(32'h0); tag_q.push_back("trace_idle_valid");
    exp_q.push_back(32'h0); tag_q.push_back("trace_idle_pc");
    @(negedge clock);
    #1 got_q.push_back({31'b0, trace_valid}); got_q.push_back(trace_pc);
    wb_valid = 1'b1; reset = 1'b1;
    exp_q.push_back(32'h0); tag_q.push_back("trace_reset_valid");
    exp_q.push_back(32'h0); tag_q.push_back("trace_reset_pc");
    @(negedge clock);
    reset = 1'b0; wb_valid = 1'b0;
    #1 got_q.push_back({31'b0, trace_valid}); got_q.push_back(trace_pc);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); t = tag_q.pop_front(); n_vec++;
      if (g !== e) begin n_err++; $display("FAIL %s: observed %h, required %h", t, g, e); end
    end
  endtask
`endif

  initial begin
    repeat (2) @(posedge clock);
    test_reset();
    test_gpr();
    test_csr();
    test_reset_override();
    test_counters();
    test_counter_wrap();
`ifdef WB_TRACE_EN
    test_trace();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
